// File: rtl/rx_byte_to_word_pack_if.sv
// Byte-stream in / packed-word out bundle between the rx core, the packer and the DMA stage.
// master = rx core / DMA side, slave = the packer.
interface rx_byte_to_word_pack_if #(
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;

  logic              sig_valid;
  logic [LEN_W-1:0]  pkt_len;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_in_strobe;
  logic              fcs_in_strobe;
  logic              fcs_ok;
  logic [DATA_W-1:0] data_to_acc;
  logic              data_ready_to_acc;

  modport master (
    output sig_valid, pkt_len, byte_in, byte_in_strobe, fcs_in_strobe, fcs_ok,
    input  data_to_acc, data_ready_to_acc
  );

  modport slave (
    input  sig_valid, pkt_len, byte_in, byte_in_strobe, fcs_in_strobe, fcs_ok,
    output data_to_acc, data_ready_to_acc
  );
endinterface

// File: rtl/rx_byte_to_word_pack.sv
// Packs the decoded PSDU byte stream into 64-bit words (ceil(pkt_len/8) per packet) and owns the rx SN.
// `define FCS_SN_INSERT_EN to wait for the FCS result and stamp {fcs_ok, SN} into the last PSDU byte.
module rx_byte_to_word_pack #(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned SN_WIDTH               = 4,
  parameter int unsigned FCS_WAIT_TOP           = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_byte_to_word_pack_if.slave rx_if,
  input  logic                  rx_pkt_sn_plus_one,
  output logic [SN_WIDTH-1:0]   rx_pkt_sn,
  output logic                  fcs_wait_timeout
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned LANES  = DATA_W / BYTE_W;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned LEN_W  = 16;
`ifdef FCS_SN_INSERT_EN
  localparam int unsigned WAIT_W = $clog2(FCS_WAIT_TOP + 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FINAL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic [SN_WIDTH-1:0] sn_q, sn_d;

  logic [LANE_W-1:0]   lane_c;
  logic [LEN_W-1:0]    last_idx_c;
  logic                is_last_c;
  logic [DATA_W-1:0]   merged_c;

`ifdef FCS_SN_INSERT_EN
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fcs_seen_q, fcs_seen_d;
  logic                fcs_ok_q, fcs_ok_d;
  logic [LANE_W-1:0]   tag_lane_c;
  logic                fin_ok_c;
  logic [DATA_W-1:0]   stamped_c;
`else
  logic                unused_c;
  assign unused_c = ^{rx_if.fcs_in_strobe, rx_if.fcs_ok, 1'(FCS_WAIT_TOP)};
`endif

  // SN advances regardless of packet state and wraps naturally.
  assign sn_d = sn_q + SN_WIDTH'(rx_pkt_sn_plus_one);

  // Current buffer with the incoming byte dropped into its lane.
  always_comb begin
    lane_c     = cnt_q[LANE_W-1:0];
    last_idx_c = len_q - LEN_W'(1);
    is_last_c  = (cnt_q == last_idx_c);
    merged_c   = buf_q;
    merged_c[BYTE_W*int'(lane_c) +: BYTE_W] = rx_if.byte_in;
  end

`ifdef FCS_SN_INSERT_EN
  // Final word with the last FCS byte replaced by {fcs_ok, SN}; SN is the one visible at emission.
  always_comb begin
    tag_lane_c = last_idx_c[LANE_W-1:0];
    fin_ok_c   = fcs_seen_q ? fcs_ok_q : (rx_if.fcs_in_strobe & rx_if.fcs_ok);
    stamped_c  = buf_q;
    stamped_c[BYTE_W*int'(tag_lane_c) +: BYTE_W] = {fin_ok_c, (BYTE_W-1)'(sn_d)};
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef FCS_SN_INSERT_EN
    wait_d     = wait_q;
    fcs_seen_d = fcs_seen_q;
    fcs_ok_d   = fcs_ok_q;
`endif

    if (rx_if.sig_valid) begin
      // A new header always wins: partial and pending final words are dropped silently.
      buf_d = '0;
      cnt_d = '0;
`ifdef FCS_SN_INSERT_EN
      wait_d     = '0;
      fcs_seen_d = 1'b0;
`endif
      if (rx_if.pkt_len != '0) begin
        len_d   = rx_if.pkt_len;
        state_d = PACK;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        PACK: begin
          if (rx_if.byte_in_strobe) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (is_last_c) begin
              state_d = FINAL;
`ifdef FCS_SN_INSERT_EN
              buf_d      = merged_c;
              wait_d     = '0;
              fcs_seen_d = rx_if.fcs_in_strobe;
              fcs_ok_d   = rx_if.fcs_ok;
`else
              buf_d   = '0;
              data_d  = merged_c;
              valid_d = 1'b1;
`endif
            end else if (lane_c == LANE_W'(LANES - 1)) begin
              buf_d   = '0;
              data_d  = merged_c;
              valid_d = 1'b1;
            end else begin
              buf_d = merged_c;
            end
          end
        end
        FINAL: begin
`ifdef FCS_SN_INSERT_EN
          if (fcs_seen_q || rx_if.fcs_in_strobe) begin
            buf_d   = '0;
            data_d  = stamped_c;
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (wait_q == WAIT_W'(FCS_WAIT_TOP - 1)) begin
            // FCS result never came: emit with fcs_ok forced low and flag it.
            buf_d     = '0;
            data_d    = stamped_c;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      sn_q      <= '0;
`ifdef FCS_SN_INSERT_EN
      wait_q     <= '0;
      fcs_seen_q <= 1'b0;
      fcs_ok_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      sn_q      <= sn_d;
`ifdef FCS_SN_INSERT_EN
      wait_q     <= wait_d;
      fcs_seen_q <= fcs_seen_d;
      fcs_ok_q   <= fcs_ok_d;
`endif
    end
  end

  assign rx_if.data_to_acc       = data_q;
  assign rx_if.data_ready_to_acc = valid_q;
  assign rx_pkt_sn               = sn_q;
  assign fcs_wait_timeout        = timeout_q;

endmodule

// File: tb/tb_rx_byte_to_word_pack.sv
// Bench for rx_byte_to_word_pack: packet-level word model with a per-cycle compare process.
// Works for both builds (FCS_SN_INSERT_EN defined or not).
`timescale 1ns/1ps
module tb_rx_byte_to_word_pack;
  localparam int unsigned SN_W     = 4;
  localparam int unsigned WAIT_TOP = 255;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          tag;
    int          lane;
    bit          ok;
    bit          to;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            plus_one;
  logic [SN_W-1:0] sn;
  logic            timeout;

  rx_byte_to_word_pack_if #(.DATA_W(64)) bus ();

  rx_byte_to_word_pack #(
    .C_M00_AXIS_TDATA_WIDTH(64),
    .SN_WIDTH(SN_W),
    .FCS_WAIT_TOP(WAIT_TOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_if(bus),
    .rx_pkt_sn_plus_one(plus_one),
    .rx_pkt_sn(sn),
    .fcs_wait_timeout(timeout)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t got_q[$];
  int   byte_cyc[$];
  int   cyc = 0;
  int   sn_m = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_words = 0;
  bit   rand_sn = 1'b0;
  bit   checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // SN reference: counts accepted pulses modulo 2^SN_W.
  always @(posedge clk) begin
    if (rst) sn_m <= 0;
    else if (plus_one) sn_m <= (sn_m + 1) % (1 << SN_W);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare of DUT outputs against the expected-word queue.
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      chk("rx_pkt_sn", 64'(sn), 64'(sn_m));
      if (bus.data_ready_to_acc) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_word: got 0x%016h with none expected (cycle %0d)", bus.data_to_acc, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.tag) e.data[8*e.lane +: 8] = {e.ok, 7'(sn_m)};
          chk("word_cycle", 64'(cyc), 64'(e.cyc));
          chk("word_data", bus.data_to_acc, e.data);
          chk("timeout_with_word", 64'(timeout), 64'(e.to));
          got_q.push_back(e);
        end
      end else begin
        chk("timeout_idle", 64'(timeout), 64'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL missed_word: no strobe, expected 0x%016h at cycle %0d (now %0d)",
                   exp_q[0].data, exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Advance one clock; inputs are re-driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.sig_valid      = 1'b0;
    bus.byte_in_strobe = 1'b0;
    bus.byte_in        = 8'($urandom);
    bus.pkt_len        = 16'($urandom);
`ifdef FCS_SN_INSERT_EN
    bus.fcs_in_strobe  = 1'b0;
`else
    bus.fcs_in_strobe  = ($urandom_range(0, 3) == 0);
`endif
    bus.fcs_ok         = 1'($urandom);
    plus_one           = rand_sn ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Sends one packet header and nsend bytes; fcs_dly < 0 means the FCS result never comes.
  task automatic run_pkt(input int len, input int nsend, input int nextra, input int gap_max,
                         input bit seq, input int fcs_dly, input bit okv);
    logic [63:0] w;
    int          c;
    int          g;
    exp_t        e;
    w = '0;
    bus.sig_valid = 1'b1;
    bus.pkt_len   = 16'(len);
    step();
    for (int k = 0; k < nsend; k++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) step();
      bus.byte_in        = seq ? 8'(k + 1) : 8'($urandom);
      bus.byte_in_strobe = 1'b1;
      c = cyc;
      byte_cyc.push_back(c);
      w[8*(k%8) +: 8] = bus.byte_in;
      if (k == len - 1) begin
        e.cyc = c + 1; e.data = w; e.tag = 1'b0; e.lane = 0; e.ok = 1'b0; e.to = 1'b0;
`ifdef FCS_SN_INSERT_EN
        e.tag  = 1'b1;
        e.lane = (len - 1) % 8;
        if (fcs_dly < 0) begin
          e.cyc = c + WAIT_TOP + 1;
          e.to  = 1'b1;
        end else begin
          e.cyc = (fcs_dly == 0) ? c + 2 : c + fcs_dly + 1;
          e.ok  = okv;
        end
        if (fcs_dly == 0) begin
          bus.fcs_in_strobe = 1'b1;
          bus.fcs_ok        = okv;
        end
`endif
        exp_q.push_back(e);
        step();
        for (int j = 1; (cyc <= e.cyc) || (j <= nextra); j++) begin
          if (j <= nextra) bus.byte_in_strobe = 1'b1;
`ifdef FCS_SN_INSERT_EN
          if (j == fcs_dly) begin
            bus.fcs_in_strobe = 1'b1;
            bus.fcs_ok        = okv;
          end
`endif
          step();
        end
      end else begin
        if (k % 8 == 7) begin
          e.cyc = c + 1; e.data = w; e.tag = 1'b0; e.lane = 0; e.ok = 1'b0; e.to = 1'b0;
          exp_q.push_back(e);
          w = '0;
        end
        step();
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nsend, r, fdly, w_before;
    rst = 1'b1;
    plus_one = 1'b0;
    bus.sig_valid = 1'b0; bus.pkt_len = '0; bus.byte_in = '0; bus.byte_in_strobe = 1'b0;
    bus.fcs_in_strobe = 1'b0; bus.fcs_ok = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", bus.data_to_acc, 64'd0);
    chk("rst_ready", 64'(bus.data_ready_to_acc), 64'd0);
    chk("rst_sn", 64'(sn), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    checking = 1'b1;
    step();

    // Bring SN to 3 with SN pulses only.
    repeat (3) begin plus_one = 1'b1; step(); end
    step();

    // 12-byte packet 0x01..0x0C back-to-back; FCS ok 5 cycles after the last byte.
    got_q.delete(); byte_cyc.delete();
    run_pkt(12, 12, 0, 0, 1'b1, 5, 1'b1);
    step();
    chk("d12_word_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("d12_word0", got_q[0].data, 64'h0807060504030201);
      chk("d12_word0_latency", 64'(got_q[0].cyc - byte_cyc[7]), 64'd1);
`ifdef FCS_SN_INSERT_EN
      chk("d12_word1", got_q[1].data, 64'h00000000830B0A09);
      chk("d12_word1_latency", 64'(got_q[1].cyc - byte_cyc[11]), 64'd6);
`else
      chk("d12_word1", got_q[1].data, 64'h000000000C0B0A09);
      chk("d12_word1_latency", 64'(got_q[1].cyc - byte_cyc[11]), 64'd1);
`endif
    end

`ifdef FCS_SN_INSERT_EN
    // FCS never arrives: forced out WAIT_TOP+1 cycles after the last byte with {0, SN}.
    got_q.delete(); byte_cyc.delete();
    run_pkt(12, 12, 2, 0, 1'b1, -1, 1'b1);
    step();
    chk("to_word_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("to_word1", got_q[1].data, 64'h00000000030B0A09);
      chk("to_latency", 64'(got_q[1].cyc - byte_cyc[11]), 64'(WAIT_TOP + 1));
    end
    // FCS strobe together with the last byte.
    got_q.delete(); byte_cyc.delete();
    run_pkt(5, 5, 0, 0, 1'b1, 0, 1'b0);
    step();
    chk("fcs_same_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      chk("fcs_same_word", got_q[0].data, 64'h0000000304030201);
      chk("fcs_same_latency", 64'(got_q[0].cyc - byte_cyc[4]), 64'd2);
    end
    // FCS on the very last cycle of the wait window is still honoured.
    got_q.delete();
    run_pkt(3, 3, 0, 0, 1'b1, WAIT_TOP, 1'b1);
    step();
    if (got_q.size() == 1) chk("fcs_edge_word", got_q[0].data, 64'h0000000000830201);
    else chk("fcs_edge_count", 64'(got_q.size()), 64'd1);
`endif

    // Full 16-byte packet, aborted packet after 5 bytes, then a full 8-byte packet.
    got_q.delete();
    run_pkt(16, 16, 0, 1, 1'b0, 2, 1'b1);
    run_pkt(20, 5, 0, 0, 1'b0, 2, 1'b1);
    run_pkt(8, 8, 0, 0, 1'b0, 2, 1'b1);
    step();
    chk("abort_word_count", 64'(got_q.size()), 64'd3);

    // Zero-length header is ignored; following bytes must not produce words.
    w_before = n_words;
    bus.sig_valid = 1'b1; bus.pkt_len = 16'd0;
    step();
    repeat (10) begin bus.byte_in_strobe = 1'b1; step(); end
    repeat (3) step();
    chk("len0_no_words", 64'(n_words - w_before), 64'd0);

    // Randomized packets with random gaps, aborts, trailing bytes and SN pulses.
    rand_sn = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len   = $urandom_range(1, 40);
      nsend = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : len;
      r     = $urandom_range(0, 15);
      fdly  = (r == 0) ? -1 : (r == 1) ? WAIT_TOP : $urandom_range(0, 8);
      run_pkt(len, nsend, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, fdly, 1'($urandom));
      if ($urandom_range(0, 1) == 0) step();
    end
    rand_sn = 1'b0;
    repeat (4) step();

    // SN wrap: pulse together with reset is ignored, then 16 pulses wrap back to 0.
    rst = 1'b1; plus_one = 1'b1;
    step();
    rst = 1'b0;
    repeat (15) begin plus_one = 1'b1; step(); end
    chk("sn_at_15", 64'(sn), 64'd15);
    plus_one = 1'b1;
    step();
    chk("sn_wrapped", 64'(sn), 64'd0);

    repeat (5) step();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
